// File: rtl/segment_transition_ctl.sv
// ---------------------------------------------------------------------------------------------
// segment_transition_ctl
//
// Segment sequencer shared by the modulation and STM paths. Holds the playback state of
// NUM_SEGMENTS sample buffers, advances the sample index on each STEP pulse, counts loop
// repetitions and switches between segments according to a latched transition request.
// It sits between the settings latch and the BRAM read port.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   update           1-cycle pulse: latch req_segment / transition_mode / transition_value
//   req_segment      requested segment
//   transition_mode  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT, 0xFF IMMEDIATE
//   transition_value SYS_TIME target (64b unsigned) or GPIO line select (bits 1:0)
//   cycle_all        per-segment last sample index, segment k at [k*IDX_W +: IDX_W]
//   rep_all          per-segment loop count minus 1, segment k at [k*REP_W +: REP_W];
//                    all-ones means loop forever
//   sys_time         synchronised system time
//   gpio_in          external triggers, already synchronised
//   step             sample-advance pulse from the frequency divider
//   segment          active segment
//   idx              current sample index
//   switch           1-cycle pulse on every segment switch
//   pending          a request is latched and waiting for its condition
//   stopped          finite repetitions exhausted, index held at the last sample
//   err              sticky: update seen with an undefined mode (cleared by rst)
// ---------------------------------------------------------------------------------------------
module segment_transition_ctl #(
    parameter int unsigned NUM_SEGMENTS = 2,
    parameter int unsigned SEG_W        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1,
    parameter int unsigned IDX_W        = 15,
    parameter int unsigned REP_W        = 16,
    parameter int unsigned NUM_GPIO     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          update,
    input  logic [SEG_W-1:0]              req_segment,
    input  logic [7:0]                    transition_mode,
    input  logic [63:0]                   transition_value,
    input  logic [NUM_SEGMENTS*IDX_W-1:0] cycle_all,
    input  logic [NUM_SEGMENTS*REP_W-1:0] rep_all,
    input  logic [63:0]                   sys_time,
    input  logic [NUM_GPIO-1:0]           gpio_in,
    input  logic                          step,
    output logic [SEG_W-1:0]              segment,
    output logic [IDX_W-1:0]              idx,
    output logic                          switch,
    output logic                          pending,
    output logic                          stopped,
    output logic                          err
);

    localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] MODE_GPIO      = 8'h02;
    localparam logic [7:0] MODE_EXT       = 8'hF0;
    localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

    // StStop is only entered with nothing pending; a request latched while stopped moves
    // to StWait with stopped_q still set, so playback stays frozen until the switch.
    typedef enum logic [1:0] {
        StRun,
        StWait,
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   cur_cycle_q, cur_cycle_d;
    logic [REP_W-1:0]   cur_rep_q, cur_rep_d;
    logic [REP_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic               stopped_q, stopped_d;
    logic               switch_q, switch_d;
    logic               err_q, err_d;
    logic               ext_armed_q, ext_armed_d;
    logic               pend_d;
    logic [SEG_W-1:0]   pend_seg_q, pend_seg_d;
    logic [7:0]         pend_mode_q, pend_mode_d;
    logic [63:0]        pend_value_q, pend_value_d;
    logic [NUM_GPIO-1:0] gpio_prev_q;

    // Combinational decode
    logic                upd_mode_ok;
    logic                upd_valid;
    logic                upd_bad;
    logic                upd_direct;
    logic                at_last;
    logic                wrap_evt;
    logic                rep_done;
    logic [NUM_GPIO-1:0] gpio_rise;
    logic                gpio_hit;
    logic                pend_cond;
    logic                fire_pend;
    logic                ext_fire;
    logic                sw_fire;
    logic                sw_arm;
    logic [SEG_W-1:0]    sw_target;
    logic [SEG_W-1:0]    next_seg;
    logic                latch_new;
    logic [IDX_W-1:0]    tgt_cycle;
    logic [REP_W-1:0]    tgt_rep;
    logic [IDX_W-1:0]    seg0_cycle;
    logic [REP_W-1:0]    seg0_rep;

    assign seg0_cycle = cycle_all[IDX_W-1:0];
    assign seg0_rep   = rep_all[REP_W-1:0];

    // ------------------------------------------------------------------ request decode
    always_comb begin
        upd_mode_ok = 1'b0;
        case (transition_mode)
            MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT, MODE_IMMEDIATE: upd_mode_ok = 1'b1;
            default: upd_mode_ok = 1'b0;
        endcase
        upd_valid  = update && upd_mode_ok;
        upd_bad    = update && !upd_mode_ok;
        // IMMEDIATE and EXT act at once unless a queued switch already owns this cycle.
        upd_direct = upd_valid &&
                     ((transition_mode == MODE_IMMEDIATE) || (transition_mode == MODE_EXT));
    end

    // ------------------------------------------------------------------ playback events
    always_comb begin
        at_last  = (idx_q == cur_cycle_q);
        wrap_evt = step && !stopped_q && at_last;
        rep_done = wrap_evt && (loop_cnt_q == cur_rep_q) && (cur_rep_q != {REP_W{1'b1}});

        gpio_rise = gpio_in & ~gpio_prev_q;
        gpio_hit  = 1'b0;
        for (int g = 0; g < NUM_GPIO; g++) begin
            if ((g < 4) && (pend_value_q[1:0] == 2'(g))) begin
                gpio_hit = gpio_rise[g];
            end
        end

        if (seg_q == SEG_W'(NUM_SEGMENTS - 1)) begin
            next_seg = '0;
        end else begin
            next_seg = seg_q + SEG_W'(1);
        end
    end

    // ------------------------------------------------------------------ switch condition
    always_comb begin
        pend_cond = 1'b0;
        case (pend_mode_q)
            // From a stopped segment any STEP counts as the sync point.
            MODE_SYNC_IDX:  pend_cond = step && (stopped_q || at_last);
            MODE_SYS_TIME:  pend_cond = (sys_time >= pend_value_q);
            MODE_GPIO:      pend_cond = gpio_hit;
            // Only reachable when an IMMEDIATE/EXT request collided with another switch.
            MODE_EXT:       pend_cond = 1'b1;
            MODE_IMMEDIATE: pend_cond = 1'b1;
            default:        pend_cond = 1'b0;
        endcase

        fire_pend = (state_q == StWait) && pend_cond;
        ext_fire  = ext_armed_q && wrap_evt;

        sw_target = seg_q;
        sw_arm    = 1'b0;
        if (fire_pend) begin
            sw_target = pend_seg_q;
            sw_arm    = (pend_mode_q == MODE_EXT);
        end else if (ext_fire) begin
            sw_target = next_seg;
            sw_arm    = 1'b1;
        end else if (upd_direct) begin
            sw_target = req_segment;
            sw_arm    = (transition_mode == MODE_EXT);
        end
        sw_fire = fire_pend || ext_fire || upd_direct;

        // A new request that arrives while a queued switch executes waits its turn.
        latch_new = upd_valid && (fire_pend || ext_fire || !upd_direct);
    end

    // ------------------------------------------------------------------ target slice select
    always_comb begin
        tgt_cycle = seg0_cycle;
        tgt_rep   = seg0_rep;
        for (int k = 0; k < NUM_SEGMENTS; k++) begin
            if (sw_target == SEG_W'(k)) begin
                tgt_cycle = cycle_all[k*IDX_W +: IDX_W];
                tgt_rep   = rep_all[k*REP_W +: REP_W];
            end
        end
    end

    // ------------------------------------------------------------------ next state
    always_comb begin
        seg_d        = seg_q;
        idx_d        = idx_q;
        cur_cycle_d  = cur_cycle_q;
        cur_rep_d    = cur_rep_q;
        loop_cnt_d   = loop_cnt_q;
        stopped_d    = stopped_q;
        ext_armed_d  = ext_armed_q;
        switch_d     = 1'b0;
        err_d        = err_q || upd_bad;
        pend_d       = (state_q == StWait);
        pend_seg_d   = pend_seg_q;
        pend_mode_d  = pend_mode_q;
        pend_value_d = pend_value_q;

        if (sw_fire) begin
            // A switch swallows a coincident STEP: the new segment starts at index 0.
            seg_d       = sw_target;
            idx_d       = '0;
            cur_cycle_d = tgt_cycle;
            cur_rep_d   = tgt_rep;
            loop_cnt_d  = '0;
            stopped_d   = 1'b0;
            ext_armed_d = sw_arm;
            switch_d    = 1'b1;
            pend_d      = 1'b0;
        end else if (step && !stopped_q) begin
            if (at_last) begin
                if (loop_cnt_q != {REP_W{1'b1}}) begin
                    loop_cnt_d = loop_cnt_q + 1'b1;
                end
                if (rep_done) begin
                    stopped_d = 1'b1;  // hold on the last sample, no wrap to 0
                end else begin
                    idx_d = '0;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (latch_new) begin
            pend_seg_d   = req_segment;
            pend_mode_d  = transition_mode;
            pend_value_d = transition_value;
            pend_d       = 1'b1;
            ext_armed_d  = 1'b0;
        end

        if (pend_d) begin
            state_d = StWait;
        end else if (stopped_d) begin
            state_d = StStop;
        end else begin
            state_d = StRun;
        end
    end

    // ------------------------------------------------------------------ state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            seg_q        <= '0;
            idx_q        <= '0;
            cur_cycle_q  <= seg0_cycle;
            cur_rep_q    <= seg0_rep;
            loop_cnt_q   <= '0;
            stopped_q    <= 1'b0;
            switch_q     <= 1'b0;
            err_q        <= 1'b0;
            ext_armed_q  <= 1'b0;
            pend_seg_q   <= '0;
            pend_mode_q  <= '0;
            pend_value_q <= '0;
            gpio_prev_q  <= '0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_d;
            idx_q        <= idx_d;
            cur_cycle_q  <= cur_cycle_d;
            cur_rep_q    <= cur_rep_d;
            loop_cnt_q   <= loop_cnt_d;
            stopped_q    <= stopped_d;
            switch_q     <= switch_d;
            err_q        <= err_d;
            ext_armed_q  <= ext_armed_d;
            pend_seg_q   <= pend_seg_d;
            pend_mode_q  <= pend_mode_d;
            pend_value_q <= pend_value_d;
            gpio_prev_q  <= gpio_in;
        end
    end

    assign segment = seg_q;
    assign idx     = idx_q;
    assign switch  = switch_q;
    assign pending = (state_q == StWait);
    assign stopped = stopped_q;
    assign err     = err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// ---------------------------------------------------------------------------------------------
// tb_segment_transition_ctl
//
// Self-checking bench for segment_transition_ctl. Each scenario task builds a list of
// per-cycle stimulus rows; driving a row pushes its expected post-edge outputs onto a
// scoreboard queue, which is popped and compared once the clock edge has produced them.
// Expected word layout: {segment, idx[14:0], switch, pending, stopped, err}.
// ---------------------------------------------------------------------------------------------
module tb_segment_transition_ctl;

    localparam int unsigned NSEG  = 2;
    localparam int unsigned SEGW  = 1;
    localparam int unsigned IDXW  = 15;
    localparam int unsigned REPW  = 16;
    localparam int unsigned NGPIO = 4;

    localparam logic [7:0] M_SYNC = 8'h00;
    localparam logic [7:0] M_TIME = 8'h01;
    localparam logic [7:0] M_GPIO = 8'h02;
    localparam logic [7:0] M_EXT  = 8'hF0;
    localparam logic [7:0] M_IMM  = 8'hFF;
    localparam logic [15:0] R_INF = 16'hFFFF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 update;
    logic [SEGW-1:0]      req_segment;
    logic [7:0]           transition_mode;
    logic [63:0]          transition_value;
    logic [NSEG*IDXW-1:0] cycle_all;
    logic [NSEG*REPW-1:0] rep_all;
    logic [63:0]          sys_time;
    logic [NGPIO-1:0]     gpio_in;
    logic                 step;
    logic [SEGW-1:0]      segment;
    logic [IDXW-1:0]      idx;
    logic                 switch;
    logic                 pending;
    logic                 stopped;
    logic                 err;

    segment_transition_ctl #(
        .NUM_SEGMENTS(NSEG),
        .SEG_W       (SEGW),
        .IDX_W       (IDXW),
        .REP_W       (REPW),
        .NUM_GPIO    (NGPIO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .update          (update),
        .req_segment     (req_segment),
        .transition_mode (transition_mode),
        .transition_value(transition_value),
        .cycle_all       (cycle_all),
        .rep_all         (rep_all),
        .sys_time        (sys_time),
        .gpio_in         (gpio_in),
        .step            (step),
        .segment         (segment),
        .idx             (idx),
        .switch          (switch),
        .pending         (pending),
        .stopped         (stopped),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        step;
        logic        upd;
        logic [7:0]  mode;
        logic        seg;
        logic [63:0] val;
        logic [63:0] st;
        logic [3:0]  gp;
        logic [19:0] exp;
    } row_t;

    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic logic [19:0] ex(int s, int i, bit sw, bit p, bit stp, bit e);
        return {1'(s), 15'(i), sw, p, stp, e};
    endfunction

    function automatic row_t r(string nm, logic st_, logic up, logic [7:0] md, logic sg,
                               logic [63:0] vl, logic [19:0] x);
        row_t o;
        o.name = nm; o.rst = 1'b0; o.step = st_; o.upd = up; o.mode = md; o.seg = sg;
        o.val = vl; o.st = 64'd0; o.gp = 4'd0; o.exp = x;
        return o;
    endfunction

    function automatic logic [19:0] observed();
        return {segment, idx, switch, pending, stopped, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input row_t x);
        exp_t e;
        rst              = x.rst;
        step             = x.step;
        update           = x.upd;
        transition_mode  = x.mode;
        req_segment      = x.seg;
        transition_value = x.val;
        sys_time         = x.st;
        gpio_in          = x.gp;
        e.name = x.name;
        e.v    = x.exp;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int c0, input logic [15:0] r0, input int c1,
                            input logic [15:0] r1);
        cycle_all = {15'(c1), 15'(c0)};
        rep_all   = {r1, r0};
        rst = 1'b1; step = 1'b0; update = 1'b0; transition_mode = 8'h00;
        req_segment = 1'b0; transition_value = 64'd0; sys_time = 64'd0; gpio_in = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Dirty the state (index, err, pending), then reset mid-operation.
    task automatic test_reset();
        row_t rows[$];
        row_t x;
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("rst_pre_step1", 1, 0, M_SYNC, 0, 0, ex(0, 1, 0, 0, 0, 0)));
        rows.push_back(r("rst_pre_step2", 1, 0, M_SYNC, 0, 0, ex(0, 2, 0, 0, 0, 0)));
        rows.push_back(r("rst_pre_bad", 0, 1, 8'h05, 1, 0, ex(0, 2, 0, 0, 0, 1)));
        rows.push_back(r("rst_pre_pend", 0, 1, M_SYNC, 1, 0, ex(0, 2, 0, 1, 0, 1)));
        x = r("rst_assert", 0, 0, M_SYNC, 0, 0, ex(0, 0, 0, 0, 0, 0));
        x.rst = 1'b1;
        rows.push_back(x);
        rows.push_back(r("rst_released", 0, 0, M_SYNC, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_infinite_loop();
        row_t rows[$];
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        for (int i = 0; i < 10; i++) begin
            rows.push_back(r("inf_step", 1, 0, M_SYNC, 0, 0, ex(0, (i + 1) % 4, 0, 0, 0, 0)));
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h required %h", e.name, i, observed(), e.v);
            end
        end
    endtask

    // Two loops of 3 points; the stop lands on the closing wrap and holds idx at 2.
    // Then a SYNC_IDX request from the stopped state fires on the next STEP.
    task automatic test_finite_rep();
        row_t rows[$];
        exp_t e;
        do_reset(2, 16'd1, 5, R_INF);
        for (int i = 0; i < 8; i++) begin
            rows.push_back(r("fin_step", 1, 0, M_SYNC, 0, 0,
                             ex(0, (i < 5) ? (i + 1) % 3 : 2, 0, 0, i >= 5, 0)));
        end
        rows.push_back(r("fin_sync_req", 0, 1, M_SYNC, 1, 0, ex(0, 2, 0, 1, 1, 0)));
        rows.push_back(r("fin_sync_idle", 0, 0, M_SYNC, 0, 0, ex(0, 2, 0, 1, 1, 0)));
        rows.push_back(r("fin_sync_fire", 1, 0, M_SYNC, 0, 0, ex(1, 0, 1, 0, 0, 0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h required %h", e.name, i, observed(), e.v);
            end
        end
    endtask

    task automatic test_immediate();
        row_t rows[$];
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("imm_step1", 1, 0, M_SYNC, 0, 0, ex(0, 1, 0, 0, 0, 0)));
        rows.push_back(r("imm_step2", 1, 0, M_SYNC, 0, 0, ex(0, 2, 0, 0, 0, 0)));
        rows.push_back(r("imm_switch", 0, 1, M_IMM, 1, 0, ex(1, 0, 1, 0, 0, 0)));
        rows.push_back(r("imm_pulse_end", 0, 0, M_SYNC, 0, 0, ex(1, 0, 0, 0, 0, 0)));
        rows.push_back(r("imm_new_seg_step", 1, 0, M_SYNC, 0, 0, ex(1, 1, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_sync_idx();
        row_t rows[$];
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("sync_step1", 1, 0, M_SYNC, 0, 0, ex(0, 1, 0, 0, 0, 0)));
        rows.push_back(r("sync_req", 0, 1, M_SYNC, 1, 0, ex(0, 1, 0, 1, 0, 0)));
        rows.push_back(r("sync_wait2", 1, 0, M_SYNC, 0, 0, ex(0, 2, 0, 1, 0, 0)));
        rows.push_back(r("sync_wait3", 1, 0, M_SYNC, 0, 0, ex(0, 3, 0, 1, 0, 0)));
        rows.push_back(r("sync_wrap_sw", 1, 0, M_SYNC, 0, 0, ex(1, 0, 1, 0, 0, 0)));
        rows.push_back(r("sync_after", 1, 0, M_SYNC, 0, 0, ex(1, 1, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_sys_time();
        row_t rows[$];
        row_t x;
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("time_req", 0, 1, M_TIME, 1, 64'd1000, ex(0, 0, 0, 1, 0, 0)));
        for (int t = 990; t <= 1002; t++) begin
            x = r("time_ramp", 0, 0, M_SYNC, 0, 0,
                  ex((t >= 1000) ? 1 : 0, 0, t == 1000, t < 1000, 0, 0));
            x.st = 64'(t);
            rows.push_back(x);
        end
        x = r("time_past_req", 0, 1, M_TIME, 0, 64'd500, ex(1, 0, 0, 1, 0, 0));
        x.st = 64'd1002;
        rows.push_back(x);
        x = r("time_past_sw", 0, 0, M_SYNC, 0, 0, ex(0, 0, 1, 0, 0, 0));
        x.st = 64'd1002;
        rows.push_back(x);
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h required %h", e.name, i, observed(), e.v);
            end
        end
    endtask

    task automatic test_gpio();
        row_t rows[$];
        row_t x;
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("gpio_req", 0, 1, M_GPIO, 1, 64'd2, ex(0, 0, 0, 1, 0, 0)));
        x = r("gpio_other_line", 0, 0, M_SYNC, 0, 0, ex(0, 0, 0, 1, 0, 0));
        x.gp = 4'b0010;
        rows.push_back(x);
        rows.push_back(r("gpio_low", 0, 0, M_SYNC, 0, 0, ex(0, 0, 0, 1, 0, 0)));
        x = r("gpio_rise_sw", 0, 0, M_SYNC, 0, 0, ex(1, 0, 1, 0, 0, 0));
        x.gp = 4'b0100;
        rows.push_back(x);
        x = r("gpio_held_high", 0, 0, M_SYNC, 0, 0, ex(1, 0, 0, 0, 0, 0));
        x.gp = 4'b0100;
        rows.push_back(x);
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_err();
        row_t rows[$];
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("err_bad_mode", 0, 1, 8'h05, 1, 0, ex(0, 0, 0, 0, 0, 1)));
        rows.push_back(r("err_then_sync", 0, 1, M_SYNC, 1, 0, ex(0, 0, 0, 1, 0, 1)));
        rows.push_back(r("err_bad_keeps", 0, 1, 8'hF1, 0, 0, ex(0, 0, 0, 1, 0, 1)));
        rows.push_back(r("err_sticky", 1, 0, M_SYNC, 0, 0, ex(0, 1, 0, 1, 0, 1)));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", e.name, observed(), e.v);
            end
        end
    endtask

    // Collision of a queued switch with a new request, latest-wins replacement and a
    // restart of the already active segment with a coincident STEP.
    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("b2b_sync_req", 0, 1, M_SYNC, 1, 0, ex(0, 0, 0, 1, 0, 0)));
        for (int i = 1; i <= 3; i++) begin
            rows.push_back(r("b2b_wait", 1, 0, M_SYNC, 0, 0, ex(0, i, 0, 1, 0, 0)));
        end
        rows.push_back(r("b2b_collide", 1, 1, M_IMM, 0, 0, ex(1, 0, 1, 1, 0, 0)));
        rows.push_back(r("b2b_queued_imm", 0, 0, M_SYNC, 0, 0, ex(0, 0, 1, 0, 0, 0)));
        rows.push_back(r("b2b_req_a", 0, 1, M_SYNC, 1, 0, ex(0, 0, 0, 1, 0, 0)));
        rows.push_back(r("b2b_req_b", 0, 1, M_TIME, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                         ex(0, 0, 0, 1, 0, 0)));
        for (int i = 1; i <= 5; i++) begin
            rows.push_back(r("b2b_latest_wins", 1, 0, M_SYNC, 0, 0, ex(0, i % 4, 0, 1, 0, 0)));
        end
        rows.push_back(r("b2b_same_seg", 1, 1, M_IMM, 0, 0, ex(0, 0, 1, 0, 0, 0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h required %h", e.name, i, observed(), e.v);
            end
        end
    endtask

    task automatic test_ext();
        row_t rows[$];
        exp_t e;
        do_reset(3, R_INF, 5, R_INF);
        rows.push_back(r("ext_req", 0, 1, M_EXT, 1, 0, ex(1, 0, 1, 0, 0, 0)));
        for (int i = 1; i <= 5; i++) begin
            rows.push_back(r("ext_seg1", 1, 0, M_SYNC, 0, 0, ex(1, i, 0, 0, 0, 0)));
        end
        rows.push_back(r("ext_adv0", 1, 0, M_SYNC, 0, 0, ex(0, 0, 1, 0, 0, 0)));
        for (int i = 1; i <= 3; i++) begin
            rows.push_back(r("ext_seg0", 1, 0, M_SYNC, 0, 0, ex(0, i, 0, 0, 0, 0)));
        end
        rows.push_back(r("ext_adv1", 1, 0, M_SYNC, 0, 0, ex(1, 0, 1, 0, 0, 0)));
        rows.push_back(r("ext_disarm", 0, 1, M_SYNC, 0, 0, ex(1, 0, 0, 1, 0, 0)));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h required %h", e.name, i, observed(), e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_infinite_loop();
        test_finite_rep();
        test_immediate();
        test_sync_idx();
        test_sys_time();
        test_gpio();
        test_err();
        test_back_to_back();
        test_ext();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
